// File: rtl/out_serial_port_pkg.sv
// ---------------------------------------------------------------------------
// out_serial_port_pkg
// Shared SAP-2 definitions used by the serial output port and its FIFO.
//   WBUS_W      : width of the W-bus data word
//   tx_state_t  : transmitter state encoding (IDLE, START, DATA, STOP)
// ---------------------------------------------------------------------------
package out_serial_port_pkg;

    localparam int WBUS_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/out_fifo.sv
// ---------------------------------------------------------------------------
// out_fifo
// Small power-of-two FIFO that queues words waiting for the transmitter.
// Ports:
//   clk    : system clock, rising edge
//   clr    : synchronous active-high reset, empties the FIFO
//   push   : write din at the tail
//   pop    : advance the head
//   din    : word to write
//   dout   : head entry, combinational
//   count  : number of stored words, 0..DEPTH
//   full   : count == DEPTH
//   empty  : count == 0
// ---------------------------------------------------------------------------
module out_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle, and popping an empty FIFO is ignored, so the storage can never
    // be corrupted even if the caller misbehaves.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are exactly log2(DEPTH) bits so they wrap for free; the count
    // carries one extra bit so that "full" and "empty" stay distinguishable.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array needs no reset; only entries between the pointers are
    // ever observed.
    always_ff @(posedge clk) begin
        if (!clr && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/out_serial_port.sv
// ---------------------------------------------------------------------------
// out_serial_port
// SAP-2 serial output port. Words loaded from the W-bus are queued in a FIFO
// and sent on 'so' as frames: start bit (0), W data bits LSB first, stop bit
// (1), each bit lasting DIV clock cycles.
// Ports:
//   clk   : system clock, rising edge
//   clr   : synchronous active-high reset, aborts any frame and empties FIFO
//   in    : data word from the bus
//   lo    : load strobe, pushes 'in' into the FIFO
//   so    : serial data out, idles high
//   busy  : a frame is in progress or words are queued
//   full  : FIFO holds DEPTH words
//   ovf   : sticky, a load was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module out_serial_port
    import out_serial_port_pkg::*;
#(
    parameter int W     = WBUS_W,
    parameter int DEPTH = 4,
    parameter int DIV   = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] in,
    input  logic         lo,
    output logic         so,
    output logic         busy,
    output logic         full,
    output logic         ovf
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(W);

    tx_state_t          state;
    tx_state_t          state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_next;
    logic [BIT_W-1:0]   bit_idx;
    logic [BIT_W-1:0]   bit_next;
    logic [W-1:0]       shift_reg;
    logic [W-1:0]       shift_next;
    logic               so_next;
    logic               busy_next;
    logic               full_next;
    logic               push;
    logic               pop;
    logic               bit_end;
    logic [W-1:0]       fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_next;
    logic               fifo_full;
    logic               fifo_empty;

    // A load into a full FIFO still succeeds when the transmitter takes the
    // head on the same edge.
    assign push    = lo && (!fifo_full || pop);
    assign bit_end = (div_cnt == DIV_W'(DIV - 1));

    out_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register. All outputs are registered here so 'so' never glitches
    // and the flags line up with the state they describe. Overflow latches
    // whenever a load is refused and only clr clears it.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            so        <= 1'b1;
            busy      <= 1'b0;
            full      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            so        <= so_next;
            busy      <= busy_next;
            full      <= full_next;
            if (lo && !push) begin
                ovf <= 1'b1;
            end
        end
    end

    // Next-state logic. The divider restarts at every bit boundary. A word is
    // popped either from IDLE or on the last edge of STOP, which lets queued
    // frames follow each other without any idle gap.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_dout;
                    div_next   = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_next   = '0;
                    state_next = DATA;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_next = '0;
                    if (bit_idx == BIT_W'(W - 1)) begin
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_idx + 1'b1;
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    div_next = '0;
                    bit_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_dout;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic, computed from the upcoming state so the registered
    // outputs change on the same edge as the state itself.
    always_comb begin
        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        full_next  = (count_next == CNT_W'(DEPTH));
        busy_next  = (state_next != IDLE) || (count_next != '0);
        case (state_next)
            START:   so_next = 1'b0;
            DATA:    so_next = shift_next[0];
            default: so_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_out_serial_port.sv
// ---------------------------------------------------------------------------
// tb_out_serial_port
// Self-checking bench for out_serial_port at W=12, DEPTH=4, DIV=4. Every
// accepted word is pushed onto an expected-frame queue; a line monitor decodes
// frames from 'so' and compares each against the head of that queue.
// ---------------------------------------------------------------------------
module tb_out_serial_port;

    localparam int W     = 12;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam int FRAME = (W + 2) * DIV;

    logic         clk;
    logic         clr;
    logic [W-1:0] in_data;
    logic         lo;
    logic         so;
    logic         busy;
    logic         full;
    logic         ovf;

    int           compared;
    int           mismatched;
    logic [W-1:0] expq [$];

    bit           mon_active;
    int           mon_cyc;
    logic [W-1:0] mon_word;
    logic [W-1:0] mon_exp;

    out_serial_port #(
        .W     (W),
        .DEPTH (DEPTH),
        .DIV   (DIV)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .in   (in_data),
        .lo   (lo),
        .so   (so),
        .busy (busy),
        .full (full),
        .ovf  (ovf)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line monitor. A low sample while idle marks start-bit sample 0; from
    // there every bit is DIV samples long and is read in the middle of its
    // span. Reset aborts any frame being decoded.
    always @(negedge clk) begin
        if (clr === 1'b1) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (so === 1'b0) begin
                mon_active = 1'b1;
                mon_cyc    = 1;
                mon_word   = '0;
            end
        end else begin
            if (mon_cyc == DIV / 2) begin
                compared++;
                if (so !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL start_bit: so=%b expected 0", so);
                end
            end else if (mon_cyc >= DIV && mon_cyc < (W + 1) * DIV) begin
                if ((mon_cyc - DIV) % DIV == DIV / 2) begin
                    mon_word[(mon_cyc - DIV) / DIV] = so;
                end
            end else if (mon_cyc == (W + 1) * DIV + DIV / 2) begin
                compared++;
                if (so !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL stop_bit: so=%b expected 1", so);
                end
            end
            if (mon_cyc == FRAME - 1) begin
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL frame_unexpected: got %h expected no frame", mon_word);
                end else begin
                    mon_exp = expq.pop_front();
                    if (mon_word !== mon_exp) begin
                        mismatched++;
                        $display("[TB] FAIL frame_data: got %h expected %h", mon_word, mon_exp);
                    end
                end
                mon_active = 1'b0;
            end
            mon_cyc++;
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for one edge and forget any frames still expected.
    task automatic do_reset();
        clr = 1'b1;
        lo  = 1'b0;
        tick();
        clr = 1'b0;
        expq.delete();
    endtask

    // Wait until busy drops; n is the number of edges waited, -1 on timeout.
    task automatic wait_idle(input int max_cyc, output int n);
        n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            n = -1;
        end
    endtask

    // Reset holds everything quiet even while lo is asserted, and nothing
    // loaded during reset survives it.
    task automatic test_reset();
        clr     = 1'b1;
        lo      = 1'b1;
        in_data = 12'h3C3;
        tick();
        tick();
        compared++;
        if (so !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_so: got %b expected 1", so); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++;
        if (full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        compared++;
        if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        clr = 1'b0;
        lo  = 1'b0;
        expq.delete();
        tick();
        tick();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_no_queue_busy: got %b expected 0", busy); end
        compared++;
        if (so !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_no_queue_so: got %b expected 1", so); end
    endtask

    // One word: so falls on the edge after the load, busy lasts one frame.
    task automatic test_single();
        int n;
        lo      = 1'b1;
        in_data = 12'hA5C;
        expq.push_back(12'hA5C);
        tick();
        lo      = 1'b0;
        in_data = 12'h000;
        compared++;
        if (so !== 1'b1) begin mismatched++; $display("[TB] FAIL single_so_before_pop: got %b expected 1", so); end
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy_after_load: got %b expected 1", busy); end
        tick();
        compared++;
        if (so !== 1'b0) begin mismatched++; $display("[TB] FAIL single_so_falls: got %b expected 0", so); end
        wait_idle(200, n);
        compared++;
        if (n !== FRAME) begin mismatched++; $display("[TB] FAIL single_busy_len: got %0d expected %0d", n, FRAME); end
        compared++;
        if (expq.size() !== 0) begin mismatched++; $display("[TB] FAIL single_frames_left: got %0d expected 0", expq.size()); end
        compared++;
        if (so !== 1'b1) begin mismatched++; $display("[TB] FAIL single_so_idle: got %b expected 1", so); end
    endtask

    // Three consecutive loads give three frames with no gap between them.
    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        int n;
        words[0] = 12'h001;
        words[1] = 12'h800;
        words[2] = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            lo      = 1'b1;
            in_data = words[i];
            expq.push_back(words[i]);
            tick();
        end
        lo = 1'b0;
        wait_idle(400, n);
        // Busy covers the pop edge and the one after it before waiting starts.
        compared++;
        if (n + 1 !== 3 * FRAME) begin mismatched++; $display("[TB] FAIL b2b_busy_len: got %0d expected %0d", n + 1, 3 * FRAME); end
        compared++;
        if (expq.size() !== 0) begin mismatched++; $display("[TB] FAIL b2b_frames_left: got %0d expected 0", expq.size()); end
    endtask

    // Six loads in a row: five fit (one leaves at once), the sixth is dropped.
    task automatic test_overflow();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            lo      = 1'b1;
            in_data = 12'h100 + 12'(i);
            if (i < 5) begin
                expq.push_back(12'h100 + 12'(i));
            end
            tick();
            if (i == 4) begin
                compared++;
                if (full !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_full_after5: got %b expected 1", full); end
                compared++;
                if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_early: got %b expected 0", ovf); end
            end
        end
        lo = 1'b0;
        compared++;
        if (ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
        wait_idle(400, n);
        compared++;
        if (n < 0) begin mismatched++; $display("[TB] FAIL ovf_drain_timeout: got %0d expected >=0", n); end
        compared++;
        if (ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf); end
        compared++;
        if (expq.size() !== 0) begin mismatched++; $display("[TB] FAIL ovf_frames_left: got %0d expected 0", expq.size()); end
    endtask

    // Full FIFO plus a load exactly on the final STOP edge: the pop makes room.
    task automatic test_full_concurrent_pop();
        int n;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            lo      = 1'b1;
            in_data = 12'h200 + 12'(i);
            expq.push_back(12'h200 + 12'(i));
            tick();
        end
        lo = 1'b0;
        // Loads were at edges k..k+4, the first pop at k+1, so the first
        // frame's last STOP edge is k+1+FRAME; stop just before it.
        repeat (FRAME - 4) tick();
        compared++;
        if (full !== 1'b1) begin mismatched++; $display("[TB] FAIL fcp_full_before: got %b expected 1", full); end
        lo      = 1'b1;
        in_data = 12'h2AA;
        expq.push_back(12'h2AA);
        tick();
        lo = 1'b0;
        compared++;
        if (full !== 1'b1) begin mismatched++; $display("[TB] FAIL fcp_full_after: got %b expected 1", full); end
        compared++;
        if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL fcp_ovf: got %b expected 0", ovf); end
        wait_idle(500, n);
        compared++;
        if (n < 0) begin mismatched++; $display("[TB] FAIL fcp_drain_timeout: got %0d expected >=0", n); end
        compared++;
        if (expq.size() !== 0) begin mismatched++; $display("[TB] FAIL fcp_frames_left: got %0d expected 0", expq.size()); end
    endtask

    // Reset 20 cycles into a frame with two words queued: everything stops.
    task automatic test_mid_frame_reset();
        bit seen_activity;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            lo      = 1'b1;
            in_data = 12'h3A1 + 12'(i * 17);
            expq.push_back(12'h3A1 + 12'(i * 17));
            tick();
        end
        lo = 1'b0;
        repeat (18) tick();
        clr = 1'b1;
        tick();
        compared++;
        if (so !== 1'b1) begin mismatched++; $display("[TB] FAIL mfr_so: got %b expected 1", so); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mfr_busy: got %b expected 0", busy); end
        compared++;
        if (full !== 1'b0) begin mismatched++; $display("[TB] FAIL mfr_full: got %b expected 0", full); end
        clr = 1'b0;
        expq.delete();
        seen_activity = 1'b0;
        repeat (100) begin
            tick();
            if (so !== 1'b1 || busy !== 1'b0) begin
                seen_activity = 1'b1;
            end
        end
        compared++;
        if (seen_activity !== 1'b0) begin mismatched++; $display("[TB] FAIL mfr_quiet: got %b expected 0", seen_activity); end
    endtask

    // Run every scenario in order and report.
    initial begin
        compared   = 0;
        mismatched = 0;
        mon_active = 1'b0;
        mon_cyc    = 0;
        mon_word   = '0;
        clr        = 1'b1;
        lo         = 1'b0;
        in_data    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_concurrent_pop();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/out_serial_port.md
Name: out_serial_port

Overview:
- Serial output port for the SAP-2 mini. It is the transmit-direction counterpart of the parallel input register.
- The CPU loads a 12-bit word from the W-bus with the `lo` strobe. The word is queued in a small FIFO.
- Each word is shifted out on a single line `so` as one frame: start bit, 12 data bits LSB first, stop bit.
- `busy` and `full` flags go to the controller so programs can poll before issuing further OUT instructions.

Parameters:
- W, 12, data word width (matches the bus).
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- DIV, 4, clock cycles per serial bit; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset; synchronous, active-high.
- in  input  W  data from the bus.
- lo  input  1  load strobe; sampled on the rising edge of clk.
- so  output  1  serial data out; idles high.
- busy  output  1  high when the FIFO is non-empty or a frame is in progress.
- full  output  1  high when the FIFO count equals DEPTH.
- ovf  output  1  sticky overflow flag: a load was dropped.

Behaviour:
- Reset: when clr=1 at an edge, the following apply after that edge, and clr overrides every other input.
  - state=IDLE, FIFO count=0, divider=0, bit index=0.
  - so=1, busy=0, full=0, ovf=0.
- Reset mid-frame: the frame aborts with no stop bit, and all queued words are discarded.
- FIFO push:
  - With lo=1 and (count<DEPTH or a pop occurs in the same cycle), `in` is written at the tail.
  - With lo=1, count==DEPTH and no pop, the word is dropped and ovf is set to 1. ovf stays 1 until clr.
- Simultaneous push and pop: both take effect and the count is unchanged. This includes the full case with a pop.
- Transmitter FSM states: IDLE, START, DATA, STOP. Every output is registered.
  - IDLE: if count>0 at an edge, pop the head into the shift register and go to START, with so=0 from that edge.
  - IDLE: a word loaded at edge k is popped at edge k+1, so so falls at edge k+1.
  - START: hold so=0 for DIV cycles, then go to DATA with so=shift[0].
  - DATA: each bit is held DIV cycles, then the register shifts right.
  - DATA: after bit W-1 has been held DIV cycles, go to STOP with so=1.
  - STOP: hold so=1 for DIV cycles. At its final edge:
    - if count>0, pop and go directly to START with no idle gap;
    - otherwise go to IDLE.
- Frame length is (W+2)*DIV cycles, which is 56 at the defaults.
- Divider: counts 0..DIV-1 and is reset at every bit boundary. With DIV=1 a bit changes every cycle.
- Flags:
  - busy = (state!=IDLE) or (count!=0), registered alongside the state.
  - full = (count==DEPTH).
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- lo held high for N cycles loads N words, subject to the full rule.
- `in` is not latched outside the push edge.

Decomposition:
- Shared include, `sap2_defs`:
  - W-bus width 12;
  - transmitter state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
- One sub-module, `out_fifo`: parameters W and DEPTH; ports clk, clr, push, pop, din, dout, count, full, empty.
  - dout is combinational from the head entry.
- out_serial_port instantiates out_fifo and contains the divider, bit counter, shift register and FSM.

Test Plan:
1. Reset: hold clr high 2 cycles with lo=1 -> so=1, busy=0, full=0, ovf=0; no word is queued after release.
2. Single word, DIV=4: lo=1 one cycle with in=12'hA5C.
   - so=0 for 4 cycles;
   - then bits 0,0,1,1,1,0,1,0,0,1,0,1, 4 cycles each;
   - then so=1; busy falls 56 cycles after pop.
3. Back-to-back: load 12'h001, 12'h800, 12'hFFF on 3 consecutive cycles -> three contiguous 56-cycle frames, no idle cycles between stop and next start, busy high for 168 cycles.
4. Overflow, DIV=4: lo high 6 consecutive cycles -> words 0-4 accepted (one popped immediately, 4 queued); full=1 after the 5th load; the 6th is dropped; ovf=1 and stays 1; the 5 frames are transmitted in order.
5. Full with concurrent pop: FIFO full, lo=1 exactly at the STOP final edge -> word accepted, count stays 4, ovf stays 0.
6. Mid-frame reset: clr=1 at cycle 20 of a frame with 2 words queued -> so=1, busy=0 after that edge; no further frames.
